// File: rtl/word_fetch_unit.sv
// Byte-wise memory fetcher assembling DATA_W words into a small output FIFO.
// Optional abort input enabled by defining WORD_FETCH_ABORT_EN.
module word_fetch_unit #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int BUF_DEPTH     = 2,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [7:0]        Count,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_CS,
  output logic              Mem_WR,
  input  logic [7:0]        Mem_Data,
  output logic              Word_Valid,
  output logic [DATA_W-1:0] Word_Data,
  input  logic              Word_Ready,
`ifdef WORD_FETCH_ABORT_EN
  input  logic              Abort,
`endif
  output logic              Busy,
  output logic              Done
);

  localparam int NB = DATA_W / 8;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [2:0]    LAST_B = 3'(NB - 1);
  localparam logic [PW-1:0] LAST_P = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [7:0]        rem;
  logic [2:0]        bidx;
  logic [2:0]        lane;
  logic [DATA_W-1:0] word, word_nx;

  logic [DATA_W-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt;
  logic              push, pop, full, abort;

`ifdef WORD_FETCH_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  assign full       = (cnt == FULL_C);
  assign Word_Valid = (cnt != '0);
  assign pop        = Word_Valid && Word_Ready;
  assign Word_Data  = Word_Valid ? buf_q[rd_ptr] : '0;
  assign Mem_Addr   = Mem_CS ? addr : '0;
  assign Mem_WR     = 1'b0;
  assign Busy       = (state != IDLE);

  // Byte lane for the incoming byte depends on fetch order and endianness.
  always_comb begin
    lane    = (LITTLE_ENDIAN != 0) ? bidx : (LAST_B - bidx);
    word_nx = word;
    for (int i = 0; i < NB; i++) begin
      if (lane == 3'(i)) word_nx[8*i +: 8] = Mem_Data;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Mem_CS   = 1'b0;
    push     = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = (Count != 8'd0) ? ADDR : FIN;
      end
      ADDR: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (!(bidx == 3'd0 && full)) begin
          Mem_CS   = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bidx != LAST_B) begin
          state_nx = ADDR;
        end else begin
          push     = 1'b1;
          state_nx = (rem == 8'd1) ? FIN : ADDR;
        end
      end
      FIN: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr <= '0;
      rem  <= '0;
      bidx <= '0;
      word <= '0;
    end else if (state == IDLE && Start && Count != 8'd0) begin
      addr <= StartAddr;
      rem  <= Count;
      bidx <= '0;
      word <= '0;
    end else if (state == DATA && !abort) begin
      word <= word_nx;
      addr <= addr + 1'b1;
      if (bidx == LAST_B) begin
        bidx <= '0;
        rem  <= rem - 8'd1;
      end else begin
        bidx <= bidx + 3'd1;
      end
    end else if (state == ADDR && abort) begin
      bidx <= '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= word_nx;
        wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_word_fetch_unit.sv
// Bench for word_fetch_unit: directed table, multi-cycle corners, random fetches.
// Two instances share stimulus: little-endian (a_) and big-endian (b_).
module tb_word_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [7:0]  count = '0;
  logic [7:0]  mem_data = '0;
  logic        ready = 1'b0;
  logic        abort = 1'b0;

  logic [15:0] a_addr, b_addr;
  logic        a_cs, b_cs, a_wr, b_wr;
  logic        a_valid, b_valid;
  logic [15:0] a_data, b_data;
  logic        a_busy, b_busy, a_done, b_done;

  word_fetch_unit #(.LITTLE_ENDIAN(1)) dut_a (
    .Clock(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr),
    .Count(count), .Mem_Addr(a_addr), .Mem_CS(a_cs), .Mem_WR(a_wr),
    .Mem_Data(mem_data), .Word_Valid(a_valid), .Word_Data(a_data),
    .Word_Ready(ready),
`ifdef WORD_FETCH_ABORT_EN
    .Abort(abort),
`endif
    .Busy(a_busy), .Done(a_done)
  );

  word_fetch_unit #(.LITTLE_ENDIAN(0)) dut_b (
    .Clock(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr),
    .Count(count), .Mem_Addr(b_addr), .Mem_CS(b_cs), .Mem_WR(b_wr),
    .Mem_Data(mem_data), .Word_Valid(b_valid), .Word_Data(b_data),
    .Word_Ready(ready),
`ifdef WORD_FETCH_ABORT_EN
    .Abort(abort),
`endif
    .Busy(b_busy), .Done(b_done)
  );

  logic [7:0] mem [65536];

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int cs_cnt = 0;
  logic [15:0] cs_log[$];
  logic [15:0] got_le[$], got_be[$], exp_le[$], exp_be[$];

  always @(posedge clk) if (a_cs) mem_data <= mem[a_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_cs) begin
        cs_cnt++;
        cs_log.push_back(a_addr);
      end
      if (a_done) done_cnt++;
      if (a_valid && ready) begin
        got_le.push_back(a_data);
        got_be.push_back(b_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wle(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a1], mem[a]};
  endfunction

  function automatic logic [15:0] wbe(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(a_addr), 32'h0);
    check({tag, "_cs"}, 32'(a_cs), 32'h0);
    check({tag, "_wr"}, 32'(a_wr), 32'h0);
    check({tag, "_valid"}, 32'(a_valid), 32'h0);
    check({tag, "_data"}, 32'(a_data), 32'h0);
    check({tag, "_busy"}, 32'(a_busy), 32'h0);
    check({tag, "_done"}, 32'(a_done), 32'h0);
  endtask

  task automatic clear_logs();
    got_le.delete();
    got_be.delete();
    exp_le.delete();
    exp_be.delete();
    cs_log.delete();
    cs_cnt = 0;
  endtask

  task automatic start_fetch(input logic [15:0] a, input logic [7:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    count = n;
    for (int i = 0; i < int'(n); i++) begin
      exp_le.push_back(wle(a + 16'(2 * i)));
      exp_be.push_back(wbe(a + 16'(2 * i)));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle count from acceptance edge to the Done cycle (-1 if never seen).
  task automatic wait_done(input bit rnd, output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (a_done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) begin
        ready = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        start_addr = 16'($urandom);
        count = 8'($urandom_range(0, 5));
      end
    end
    start = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a_valid) break;
    end
    check("drain_empty", 32'(a_valid), 32'h0);
  endtask

  task automatic compare_words(input string tag);
    int m;
    check({tag, "_nwords"}, 32'(got_le.size()), 32'(exp_le.size()));
    m = (got_le.size() < exp_le.size()) ? got_le.size() : exp_le.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_le"}, 32'(got_le[i]), 32'(exp_le[i]));
      check({tag, "_be"}, 32'(got_be[i]), 32'(exp_be[i]));
    end
  endtask

  task automatic check_addr_seq(input string tag, input logic [15:0] a);
    for (int j = 0; j < cs_log.size(); j++)
      check({tag, "_maddr"}, 32'(cs_log[j]), 32'(16'(a + 16'(j))));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  n;
    logic [15:0] w0_le;
    logic [15:0] w0_be;
    int          lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat;
    int d0;
    logic [15:0] ra;
    logic [7:0]  rn;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    mem[16'h0013] = 8'h44;
    mem[16'hFFFF] = 8'hAB;
    mem[16'h0000] = 8'hCD;

    tbl[0] = '{16'h0010, 8'd2, 16'h2211, 16'h1122, 9};
    tbl[1] = '{16'hFFFF, 8'd1, 16'hCDAB, 16'hABCD, 5};
    tbl[2] = '{16'h0012, 8'd1, 16'h4433, 16'h3344, 5};
    tbl[3] = '{16'h1234, 8'd0, 16'h0000, 16'h0000, 1};

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      d0 = done_cnt;
      start_fetch(tbl[i].addr, tbl[i].n);
      wait_done(1'b0, lat);
      check("tbl_latency", 32'(lat), 32'(tbl[i].lat));
      drain();
      check("tbl_done_once", 32'(done_cnt - d0), 32'd1);
      check("tbl_cs_count", 32'(cs_cnt), 32'(2 * int'(tbl[i].n)));
      check_addr_seq("tbl", tbl[i].addr);
      if (tbl[i].n != 8'd0) begin
        check("tbl_w0_le", 32'(got_le.size() > 0 ? got_le[0] : 16'hxxxx),
              32'(tbl[i].w0_le));
        check("tbl_w0_be", 32'(got_be.size() > 0 ? got_be[0] : 16'hxxxx),
              32'(tbl[i].w0_be));
      end
      compare_words("tbl");
    end

    // Back-pressure: buffer fills, fetch holds, single pop releases it.
    clear_logs();
    ready = 1'b0;
    start_fetch(16'h0100, 8'd4);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("stall_cs", 32'(a_cs), 32'h0);
    check("stall_addr0", 32'(a_addr), 32'h0);
    check("stall_busy", 32'(a_busy), 32'h1);
    check("stall_cs_count", 32'(cs_cnt), 32'd4);
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    check("stall_resume_cs", 32'(a_cs), 32'h1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall2_cs", 32'(a_cs), 32'h0);
    check("stall2_cs_count", 32'(cs_cnt), 32'd6);
    @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done(1'b0, lat);
    check("stall_done_seen", 32'(lat > 0), 32'h1);
    drain();
    check_addr_seq("stall", 16'h0100);
    compare_words("stall");

    // Buffered word survives past Done until popped.
    clear_logs();
    ready = 1'b0;
    start_fetch(16'h0200, 8'd1);
    wait_done(1'b0, lat);
    check("keep_latency", 32'(lat), 32'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("keep_valid", 32'(a_valid), 32'h1);
    check("keep_data", 32'(a_data), 32'(wle(16'h0200)));
    check("keep_busy", 32'(a_busy), 32'h0);
    drain();
    compare_words("keep");

    // Asynchronous reset in the DATA cycle of word 2.
    clear_logs();
    ready = 1'b0;
    start_fetch(16'h0010, 8'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("prerst_valid", 32'(a_valid), 32'h1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_empty", 32'(a_valid), 32'h0);
    ready = 1'b1;
    start_fetch(16'h0012, 8'd1);
    wait_done(1'b0, lat);
    check("postrst_latency", 32'(lat), 32'd5);
    drain();
    compare_words("postrst");

`ifdef WORD_FETCH_ABORT_EN
    clear_logs();
    ready = 1'b1;
    d0 = done_cnt;
    start_fetch(16'h0010, 8'd2);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle", 32'(a_busy), 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    void'(exp_le.pop_back());
    void'(exp_be.pop_back());
    compare_words("abort");
`endif

    // Random fetches with random back-pressure and ignored Start pulses.
    for (int it = 0; it < 20; it++) begin
      clear_logs();
      ra = 16'($urandom);
      rn = 8'($urandom_range(0, 5));
      d0 = done_cnt;
      ready = 1'($urandom_range(0, 1));
      start_fetch(ra, rn);
      wait_done(1'b1, lat);
      check("rnd_done_seen", 32'(lat > 0), 32'h1);
      drain();
      check("rnd_done_once", 32'(done_cnt - d0), 32'd1);
      check("rnd_cs_count", 32'(cs_cnt), 32'(2 * int'(rn)));
      check_addr_seq("rnd", ra);
      compare_words("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/word_fetch_unit.md
WORD_FETCH_UNIT -- requirements
Module: word_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, assembled word width; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 16, byte-memory address width.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, output word buffer depth; range 1..8.
REQ-004 SHALL have parameter LITTLE_ENDIAN, default 1; 1 = first fetched byte goes to bits [7:0], 0 = first fetched byte goes to the top byte.
REQ-005 SHALL have ports (name  direction  width  meaning):
- Clock  in  1  single clock, rising edge; one clock, reset is asynchronous and active-low.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  fetch request; sampled only in IDLE.
- StartAddr  in  ADDR_W  first byte address.
- Count  in  8  number of words to fetch.
- Mem_Addr  out  ADDR_W  byte address to memory.
- Mem_CS  out  1  read strobe, active-high.
- Mem_WR  out  1  constant 0 (read only).
- Mem_Data  in  8  read byte, valid the cycle after the Mem_CS cycle.
- Word_Valid  out  1  buffer non-empty.
- Word_Data  out  DATA_W  head-of-buffer word.
- Word_Ready  in  1  consumer pop; a pop occurs when Word_Valid and Word_Ready are both high at the edge.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the last word enters the buffer.

Function
REQ-006 SHALL implement FSM states IDLE, ADDR, DATA and FIN.
REQ-007 IDLE with Start=1 and Count!=0 SHALL latch StartAddr and Count, clear the byte index, and go to ADDR.
REQ-008 IDLE with Start=1 and Count=0 SHALL go to FIN with no memory access.
REQ-009 ADDR SHALL drive Mem_Addr = current address and Mem_CS=1, then go to DATA, except per REQ-012.
REQ-010 DATA SHALL capture Mem_Data into the byte lane selected by the byte index and LITTLE_ENDIAN, then increment the address.
REQ-011 After DATA, the FSM SHALL return to ADDR if bytes remain in the word; otherwise it SHALL push the word, decrement the remaining count, and go to ADDR if words remain, else FIN.
REQ-012 ADDR for the first byte of a word SHALL hold with Mem_CS=0 while the buffer holds BUF_DEPTH entries; a pop in that cycle releases the hold on the next cycle.
REQ-013 Per-word latency SHALL be 2*(DATA_W/8) cycles when not stalled (4 cycles at default).
REQ-014 The address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-015 FIN SHALL assert Done for one cycle and go to IDLE.
REQ-016 Start while Busy SHALL be ignored.
REQ-017 The buffer SHALL be a FIFO of BUF_DEPTH entries.
- Word_Data shows the head entry.
- A simultaneous push and pop SHALL both take effect.
- Buffered words SHALL remain valid after Done until popped.
- Mem_Addr SHALL be 0 whenever Mem_CS=0.

Reset
REQ-018 Reset low SHALL immediately force IDLE, empty the buffer, and clear the address, count and byte index.
REQ-019 During reset: Mem_Addr=0, Mem_CS=0, Mem_WR=0, Word_Valid=0, Word_Data=0, Busy=0, Done=0.
REQ-020 Reset mid-fetch SHALL discard any partial word and all buffered words; no Done SHALL be issued.

Configuration
REQ-021 Macro WORD_FETCH_ABORT_EN SHALL control the Abort feature.
- Defined: SHALL add input port Abort (1 bit). Abort=1 in ADDR or DATA SHALL discard the partial word, go to IDLE next cycle and not pulse Done. Words already buffered SHALL be kept. Abort in IDLE or FIN SHALL have no effect.
- Undefined: no Abort port; the fetch always runs to FIN.

Verification
REQ-022 Defaults; StartAddr=0x0010, Count=2, memory bytes 0x10..0x13 = 11,22,33,44; Word_Ready=1 -> words 0x2211 then 0x4433; Done 9 cycles after Start acceptance.
REQ-023 LITTLE_ENDIAN=0, same stimulus -> words 0x1122 then 0x3344.
REQ-024 BUF_DEPTH=2, Count=4, Word_Ready=0 -> after 2 words, FSM holds in ADDR with Mem_CS=0; one pop -> fetch resumes the next cycle; no word lost or duplicated.
REQ-025 StartAddr=0xFFFF, Count=1 -> Mem_Addr sequence 0xFFFF then 0x0000; Count=0 -> Done one cycle after Start, Mem_CS never asserted.
REQ-026 Reset asserted during the DATA cycle of word 2 -> all outputs at reset values asynchronously; a later Start with Count=1 fetches correctly. With WORD_FETCH_ABORT_EN: Abort on word 2 -> word 1 still delivered, no Done.
